dm_responder: RTL and testbench
===============================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL take parameter DEPTH_WORDS, default 4096, meaning the number of 32-bit data words, power of two.
REQ-002 SHALL take parameter TRACE_DEPTH, default 8, meaning the number of write-trace FIFO entries, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port m_data_addr, input, 32 bits: CPU byte address for the M-stage access.
REQ-006 SHALL have port m_data_wdata, input, 32 bits: CPU store data, already lane-aligned.
REQ-007 SHALL have port m_data_byteen, input, 4 bits: per-byte write enable; 0 means no write.
REQ-008 SHALL have port m_inst_addr, input, 32 bits: PC of the M-stage instruction, used for trace only.
REQ-009 SHALL have port m_data_rdata, output, 32 bits: read word at the addressed word.
REQ-010 SHALL have port dm_ready, output, 1 bit: high when the memory accepts accesses; the CPU stalls while it is low.
REQ-011 SHALL have port addr_err, output, 1 bit: sticky flag for any write to an out-of-range address.
REQ-012 SHALL have port trace_valid, output, 1 bit: a trace record is available.
REQ-013 SHALL have port trace_ready, input, 1 bit: the consumer accepts the record.
REQ-014 SHALL have port trace_pc, output, 32 bits: m_inst_addr of the traced store.
REQ-015 SHALL have port trace_addr, output, 32 bits: word-aligned address of the store (m_data_addr & 32'hfffffffc).
REQ-016 SHALL have port trace_data, output, 32 bits: full merged word after the store.
REQ-017 SHALL have port trace_ovf, output, 1 bit: sticky flag set when a record is dropped because the FIFO is full.

Function
REQ-018 SHALL implement a two-state FSM: CLEAR, in which one word per cycle is zeroed via a 0..DEPTH_WORDS-1 index counter, and RUN; leaving reset enters CLEAR at index 0, and CLEAR moves to RUN in the cycle after index DEPTH_WORDS-1 is written.
REQ-019 SHALL drive dm_ready low in CLEAR and high in RUN; the first access is accepted DEPTH_WORDS cycles after reset release.
REQ-020 SHALL make the word index m_data_addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] are ignored; the address is in range when m_data_addr < DEPTH_WORDS*4.
REQ-021 SHALL make m_data_rdata combinational from the addressed word when in RUN and in range, and 32'h0 otherwise.
REQ-022 SHALL, in RUN with a write, merge each lane k where byteen[k]=1 from wdata, keep other lanes from the stored word, and write at the clock edge; a read in the same cycle returns the old word.
REQ-023 SHALL ignore writes in CLEAR, drop no trace for them, and leave addr_err unchanged.
REQ-024 SHALL ignore an out-of-range write in RUN, set addr_err, and produce no trace record.
REQ-025 SHALL push {m_inst_addr, aligned addr, merged word} into the trace FIFO on each accepted write; trace outputs show the head entry; a pop occurs when trace_valid and trace_ready are both high.
REQ-026 SHALL, on simultaneous push and pop with the FIFO full, accept both and keep the count unchanged.
REQ-027 SHALL, on a push with the FIFO full and no pop, drop the record, set trace_ovf, and still perform the memory write.
REQ-028 SHALL use read and write pointers that wrap modulo TRACE_DEPTH, with a count of width log2(TRACE_DEPTH)+1.

Reset
REQ-029 SHALL, while reset is low, asynchronously force: FSM=CLEAR, clear index=0, dm_ready=0, addr_err=0, trace_ovf=0, FIFO empty, trace_valid=0.
REQ-030 SHALL, while reset is low, hold trace_pc, trace_addr, trace_data and m_data_rdata at 0.
REQ-031 SHALL, on reset asserted mid-CLEAR or mid-RUN, discard all progress and pending trace records and restart the clear after release.

Configuration
REQ-032 SHALL, with macro DM_RESPONDER_TRACE_EN defined, implement the trace FIFO and trace outputs as specified.
REQ-033 SHALL, without DM_RESPONDER_TRACE_EN, instantiate no FIFO, tie trace_valid, trace_pc, trace_addr, trace_data and trace_ovf to 0, ignore trace_ready, and leave memory behaviour unchanged.

Verification
REQ-034 SHALL cover reset release with DEPTH_WORDS=16: dm_ready rises exactly 16 cycles later, and every m_data_rdata is 0.
REQ-035 SHALL cover a store of 32'h11223344 with byteen=4'hf to addr 32'h8, then byteen=4'b0010 with wdata 32'h0000AB00 to addr 32'h9: rdata at 32'h8 is 32'h1122AB44, and the trace records have trace_addr 32'h8 and data 32'h11223344 then 32'h1122AB44.
REQ-036 SHALL cover TRACE_DEPTH=8 with trace_ready=0 and 9 stores: trace_ovf=1, 8 records are retained, and the 9th store is still visible in memory.
REQ-037 SHALL cover a store to addr 32'h40 with DEPTH_WORDS=16: addr_err=1, no trace record, and memory is unchanged.
REQ-038 SHALL cover a store during CLEAR, then reset pulsed low mid-RUN: the store is ignored, all flags clear, and the clear restarts at index 0.
REQ-039 SHALL cover a full FIFO with trace_ready=1 and a store in the same cycle: the count stays at 8 and trace_ovf stays 0.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: word-addressed data memory with a power-on clear sweep,
// byte-lane merged stores, a sticky out-of-range write flag and an optional
// store-trace FIFO (enabled by defining DM_RESPONDER_TRACE_EN).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | zeroing one word per cycle; accesses are stalled/ignored
// S_RUN   | memory live; reads/writes accepted
module dm_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int TRACE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        dm_ready,
  output logic        addr_err,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_ovf
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_e;

  state_e          state_q;
  logic [AW-1:0]   clr_idx_q;
  logic            dm_ready_q;
  logic            addr_err_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [AW-1:0]   widx;
  logic            in_range;
  logic            wr_req;
  logic            wr_accept;
  logic [31:0]     old_word;
  logic [31:0]     merged_word;

  assign widx      = m_data_addr[AW+1:2];
  assign in_range  = (m_data_addr[31:AW+2] == '0);
  assign wr_req    = (state_q == S_RUN) && (m_data_byteen != 4'h0);
  assign wr_accept = wr_req && in_range;
  assign old_word  = mem_q[widx];

  // Byte-lane merge of store data over the currently stored word.
  always_comb begin
    merged_word = old_word;
    for (int k = 0; k < 4; k++) begin
      if (m_data_byteen[k]) merged_word[8*k +: 8] = m_data_wdata[8*k +: 8];
    end
  end

  // Clear sweep / run FSM with registered ready output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_CLEAR;
      clr_idx_q  <= '0;
      dm_ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clr_idx_q == LAST_IDX) begin
            state_q    <= S_RUN;
            dm_ready_q <= 1'b1;
            clr_idx_q  <= '0;
          end else begin
            clr_idx_q  <= clr_idx_q + AW'(1);
          end
        end
        default: begin
          state_q    <= S_RUN;
          dm_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Memory array: cleared during the sweep, merged store in RUN.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[clr_idx_q] <= 32'h0;
    end else if (wr_accept) begin
      mem_q[widx] <= merged_word;
    end
  end

  // Sticky flag for stores that fall outside the memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    addr_err_q <= 1'b0;
    else if (wr_req && !in_range)  addr_err_q <= 1'b1;
  end

  assign dm_ready     = dm_ready_q;
  assign addr_err     = addr_err_q;
  assign m_data_rdata = ((state_q == S_RUN) && in_range) ? old_word : 32'h0;

`ifdef DM_RESPONDER_TRACE_EN
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fifo_pc_q   [TRACE_DEPTH];
  logic [31:0]   fifo_addr_q [TRACE_DEPTH];
  logic [31:0]   fifo_data_q [TRACE_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q;
  logic          full, do_pop, do_push;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^m_data_addr[1:0];
  assign full    = (cnt_q == CW'(TRACE_DEPTH));
  assign do_pop  = trace_valid && trace_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = wr_accept && (!full || do_pop);

  // Occupancy next-state.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer, occupancy and overflow bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
      if (wr_accept && full && !do_pop) ovf_q <= 1'b1;
    end
  end

  // Trace record storage.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_pc_q[wr_ptr_q]   <= m_inst_addr;
      fifo_addr_q[wr_ptr_q] <= {m_data_addr[31:2], 2'b00};
      fifo_data_q[wr_ptr_q] <= merged_word;
    end
  end

  // Head fields read as zero when empty so reset shows a clean interface.
  assign trace_valid = (cnt_q != '0);
  assign trace_pc    = trace_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;
  assign trace_addr  = trace_valid ? fifo_addr_q[rd_ptr_q] : 32'h0;
  assign trace_data  = trace_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
  assign trace_ovf   = ovf_q;
`else
  logic unused_trace;

  assign unused_trace = ^{m_inst_addr, trace_ready, m_data_addr[1:0]};
  assign trace_valid  = 1'b0;
  assign trace_pc     = 32'h0;
  assign trace_addr   = 32'h0;
  assign trace_data   = 32'h0;
  assign trace_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder with DEPTH_WORDS=16, TRACE_DEPTH=8.
// Trace expectations follow whether DM_RESPONDER_TRACE_EN is defined.
module tb_dm_responder;

  localparam int DW = 16;
  localparam int TD = 8;
`ifdef DM_RESPONDER_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m_data_addr = '0;
  logic [31:0] m_data_wdata = '0;
  logic [3:0]  m_data_byteen = '0;
  logic [31:0] m_inst_addr = '0;
  logic [31:0] m_data_rdata;
  logic        dm_ready;
  logic        addr_err;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  dm_responder #(.DEPTH_WORDS(DW), .TRACE_DEPTH(TD)) dut (
    .clk(clk), .reset(reset),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
    .m_data_rdata(m_data_rdata), .dm_ready(dm_ready), .addr_err(addr_err),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_ovf(trace_ovf)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; the store commits at the next rising edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] pc);
    m_data_addr = a; m_data_wdata = d; m_data_byteen = be; m_inst_addr = pc;
    @(negedge clk);
    m_data_byteen = 4'h0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!dm_ready && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic pop_all(output int n, output logic [31:0] first_pc,
                         output logic [31:0] last_pc, output logic [31:0] last_data);
    n = 0; first_pc = '0; last_pc = '0; last_data = '0;
    trace_ready = 1'b1;
    while (trace_valid && n < 20) begin
      if (n == 0) first_pc = trace_pc;
      last_pc = trace_pc;
      last_data = trace_data;
      @(negedge clk);
      n++;
    end
    trace_ready = 1'b0;
  endtask

  task automatic test_reset();
    int cycles;
    bit bad_clear_rd;
    reset = 1'b0;
    m_data_addr = 32'h8;
    @(negedge clk); #1;
    n_checks++; if (dm_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", dm_ready); end
    n_checks++; if (addr_err !== 1'b0 || trace_ovf !== 1'b0 || trace_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_flags got err=%b ovf=%b valid=%b want 0 0 0", addr_err, trace_ovf, trace_valid); end
    n_checks++; if ({m_data_rdata, trace_pc, trace_addr, trace_data} !== 128'h0) begin n_fail++;
      $display("FAIL rst_data got rdata=%h pc=%h addr=%h data=%h want 0", m_data_rdata, trace_pc, trace_addr, trace_data); end
    @(negedge clk);
    reset = 1'b1;
    cycles = 0;
    bad_clear_rd = 1'b0;
    while (!dm_ready && cycles < 100) begin
      if (m_data_rdata !== 32'h0) bad_clear_rd = 1'b1;
      if (cycles == 5) begin
        m_data_addr = 32'h8; m_data_wdata = 32'hFFFFFFFF; m_data_byteen = 4'hf; m_inst_addr = 32'h50;
      end else begin
        m_data_byteen = 4'h0;
      end
      @(negedge clk);
      cycles++;
    end
    m_data_byteen = 4'h0;
    n_checks++; if (cycles != DW) begin n_fail++; $display("FAIL ready_latency got %0d want %0d", cycles, DW); end
    n_checks++; if (bad_clear_rd) begin n_fail++; $display("FAIL clear_rdata got nonzero want 0"); end
    n_checks++; if (addr_err !== 1'b0 || trace_valid !== 1'b0) begin n_fail++;
      $display("FAIL clear_store_side got err=%b valid=%b want 0 0", addr_err, trace_valid); end
    for (int i = 0; i < DW; i++) begin
      m_data_addr = i * 4; #1;
      n_checks++; if (m_data_rdata !== 32'h0) begin n_fail++;
        $display("FAIL cleared_word%0d got %h want 0", i, m_data_rdata); end
    end
  endtask

  task automatic test_merge();
    @(negedge clk);
    m_data_addr = 32'h8; m_data_wdata = 32'h11223344; m_data_byteen = 4'hf; m_inst_addr = 32'h100;
    #1;
    n_checks++; if (m_data_rdata !== 32'h0) begin n_fail++; $display("FAIL same_cycle_old got %h want 0", m_data_rdata); end
    @(negedge clk);
    m_data_byteen = 4'h0; #1;
    n_checks++; if (m_data_rdata !== 32'h11223344) begin n_fail++; $display("FAIL full_store got %h want 11223344", m_data_rdata); end
    m_data_addr = 32'h9; m_data_wdata = 32'h0000AB00; m_data_byteen = 4'b0010; m_inst_addr = 32'h104;
    #1;
    n_checks++; if (m_data_rdata !== 32'h11223344) begin n_fail++; $display("FAIL unaligned_read got %h want 11223344", m_data_rdata); end
    @(negedge clk);
    m_data_byteen = 4'h0; m_data_addr = 32'h8; #1;
    n_checks++; if (m_data_rdata !== 32'h1122AB44) begin n_fail++; $display("FAIL lane_merge got %h want 1122ab44", m_data_rdata); end
    n_checks++; if (trace_valid !== TRACE || trace_pc !== (TRACE ? 32'h100 : 32'h0) ||
                    trace_addr !== (TRACE ? 32'h8 : 32'h0) || trace_data !== (TRACE ? 32'h11223344 : 32'h0)) begin
      n_fail++; $display("FAIL trace_rec0 got v=%b pc=%h a=%h d=%h", trace_valid, trace_pc, trace_addr, trace_data); end
    @(negedge clk);
    trace_ready = 1'b1;
    @(negedge clk);
    trace_ready = 1'b0; #1;
    n_checks++; if (trace_valid !== TRACE || trace_pc !== (TRACE ? 32'h104 : 32'h0) ||
                    trace_addr !== (TRACE ? 32'h8 : 32'h0) || trace_data !== (TRACE ? 32'h1122AB44 : 32'h0)) begin
      n_fail++; $display("FAIL trace_rec1 got v=%b pc=%h a=%h d=%h", trace_valid, trace_pc, trace_addr, trace_data); end
    @(negedge clk);
    trace_ready = 1'b1;
    @(negedge clk);
    trace_ready = 1'b0; #1;
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL trace_drained got %b want 0", trace_valid); end
  endtask

  task automatic test_addr_err();
    @(negedge clk);
    store(32'h3C, 32'h5A5A5A5A, 4'hf, 32'h180);
    m_data_addr = 32'h3C; #1;
    n_checks++; if (m_data_rdata !== 32'h5A5A5A5A || addr_err !== 1'b0) begin n_fail++;
      $display("FAIL last_word got %h err=%b want 5a5a5a5a 0", m_data_rdata, addr_err); end
    n_checks++; if (trace_valid !== TRACE || trace_addr !== (TRACE ? 32'h3C : 32'h0)) begin n_fail++;
      $display("FAIL last_word_trace got v=%b a=%h", trace_valid, trace_addr); end
    @(negedge clk);
    trace_ready = 1'b1;
    @(negedge clk);
    trace_ready = 1'b0;
    store(32'h40, 32'hDEADBEEF, 4'hf, 32'h184);
    #1;
    n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_err got %b want 1", addr_err); end
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL oor_notrace got %b want 0", trace_valid); end
    m_data_addr = 32'h40; #1;
    n_checks++; if (m_data_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_read got %h want 0", m_data_rdata); end
    m_data_addr = 32'h0; #1;
    n_checks++; if (m_data_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_alias got %h want 0", m_data_rdata); end
    m_data_addr = 32'h8; #1;
    n_checks++; if (m_data_rdata !== 32'h1122AB44) begin n_fail++; $display("FAIL oor_keep got %h want 1122ab44", m_data_rdata); end
  endtask

  task automatic test_overflow();
    int n;
    logic [31:0] fpc, lpc, ldat;
    @(negedge clk);
    trace_ready = 1'b0;
    for (int i = 0; i < TD + 1; i++) store(i * 4, 32'hA0 + i, 4'hf, 32'h200 + 4 * i);
    #1;
    n_checks++; if (trace_ovf !== TRACE) begin n_fail++; $display("FAIL ovf_set got %b want %b", trace_ovf, TRACE); end
    m_data_addr = 32'h20; #1;
    n_checks++; if (m_data_rdata !== 32'hA8) begin n_fail++; $display("FAIL ovf_mem got %h want a8", m_data_rdata); end
    n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", addr_err); end
    @(negedge clk);
    pop_all(n, fpc, lpc, ldat);
    n_checks++; if (n != (TRACE ? TD : 0)) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", n, TRACE ? TD : 0); end
    n_checks++; if (fpc !== (TRACE ? 32'h200 : 32'h0) || lpc !== (TRACE ? 32'h21C : 32'h0) ||
                    ldat !== (TRACE ? 32'hA7 : 32'h0)) begin n_fail++;
      $display("FAIL ovf_records got first=%h last=%h data=%h", fpc, lpc, ldat); end
    n_checks++; if (trace_ovf !== TRACE) begin n_fail++; $display("FAIL ovf_sticky got %b want %b", trace_ovf, TRACE); end
  endtask

  task automatic test_reset_mid_run();
    int cycles;
    @(negedge clk);
    store(32'h10, 32'h77, 4'hf, 32'h280);
    store(32'h14, 32'h78, 4'hf, 32'h284);
    reset = 1'b0; m_data_addr = 32'h10; #1;
    n_checks++; if (addr_err !== 1'b0 || trace_ovf !== 1'b0 || trace_valid !== 1'b0 || dm_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrun_flags got err=%b ovf=%b v=%b rdy=%b want 0", addr_err, trace_ovf, trace_valid, dm_ready); end
    n_checks++; if (m_data_rdata !== 32'h0) begin n_fail++; $display("FAIL midrun_rdata got %h want 0", m_data_rdata); end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_ready(cycles);
    n_checks++; if (cycles != DW) begin n_fail++; $display("FAIL midclear_latency got %0d want %0d", cycles, DW); end
    #1;
    n_checks++; if (m_data_rdata !== 32'h0) begin n_fail++; $display("FAIL reclear_word got %h want 0", m_data_rdata); end
    n_checks++; if (trace_valid !== 1'b0 || addr_err !== 1'b0) begin n_fail++;
      $display("FAIL reclear_flags got v=%b err=%b want 0 0", trace_valid, addr_err); end
  endtask

  task automatic test_full_push_pop();
    int n;
    logic [31:0] fpc, lpc, ldat;
    @(negedge clk);
    for (int i = 0; i < TD; i++) store(i * 4, 32'hC0 + i, 4'hf, 32'h300 + 4 * i);
    #1;
    n_checks++; if (trace_ovf !== 1'b0 || trace_valid !== TRACE) begin n_fail++;
      $display("FAIL full_state got ovf=%b v=%b", trace_ovf, trace_valid); end
    @(negedge clk);
    trace_ready = 1'b1;
    store(32'h24, 32'hC8, 4'hf, 32'h320);
    trace_ready = 1'b0; #1;
    n_checks++; if (trace_ovf !== 1'b0) begin n_fail++; $display("FAIL pushpop_ovf got %b want 0", trace_ovf); end
    n_checks++; if (trace_pc !== (TRACE ? 32'h304 : 32'h0)) begin n_fail++; $display("FAIL pushpop_head got %h", trace_pc); end
    m_data_addr = 32'h24; #1;
    n_checks++; if (m_data_rdata !== 32'hC8) begin n_fail++; $display("FAIL pushpop_mem got %h want c8", m_data_rdata); end
    @(negedge clk);
    pop_all(n, fpc, lpc, ldat);
    n_checks++; if (n != (TRACE ? TD : 0)) begin n_fail++; $display("FAIL pushpop_count got %0d want %0d", n, TRACE ? TD : 0); end
    n_checks++; if (lpc !== (TRACE ? 32'h320 : 32'h0) || ldat !== (TRACE ? 32'hC8 : 32'h0)) begin n_fail++;
      $display("FAIL pushpop_last got pc=%h data=%h", lpc, ldat); end
  endtask

  initial begin
    test_reset();
    test_merge();
    test_addr_err();
    test_overflow();
    test_reset_mid_run();
    test_full_push_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
